// File: rtl/int_ctrl_if.sv
// Bus between the interrupt controller and its environment: request lines,
// mask programming, core handshake and status.
interface int_ctrl_if #(
  parameter int NSRC = 4
);
  localparam int VW = $clog2(NSRC);

  logic [NSRC-1:0] irq_in;
  logic            mask_we;
  logic [NSRC-1:0] mask_wdata;
  logic            int_ack;
  logic            rti;
  logic            intr;
  logic [VW-1:0]   int_vec;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] mask;
  logic            busy;

  // master: the controller; slave: the core / environment side
  modport master (
    input  irq_in, mask_we, mask_wdata, int_ack, rti,
    output intr, int_vec, pending, mask, busy
  );

  modport slave (
    output irq_in, mask_we, mask_wdata, int_ack, rti,
    input  intr, int_vec, pending, mask, busy
  );
endinterface

// File: rtl/int_ctrl.sv
// Interrupt request controller: synchronises request lines, latches rising
// edges, masks, picks the lowest-index eligible source and runs the core handshake.
module int_ctrl #(
  parameter int NSRC        = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  int_ctrl_if.master  bus
);
  localparam int VW = $clog2(NSRC);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state;

  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] ref_q;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] clr;
  logic [VW-1:0]   winner;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      ref_q <= '0;
    end else begin
      sync_q[0] <= bus.irq_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      ref_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    rise     = sync_q[SYNC_STAGES-1] & ~ref_q;
    eligible = bus.pending & ~bus.mask;
    // scan from the top so the lowest set index is the last to be written
    winner   = '0;
    for (int unsigned i = 0; i < NSRC; i++)
      if (eligible[NSRC-1-i]) winner = VW'(NSRC-1-i);
    clr = '0;
    if (state == REQ && bus.int_ack) clr[bus.int_vec] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.intr    <= 1'b0;
      bus.int_vec <= '0;
      bus.pending <= '0;
      bus.mask    <= '0;
      bus.busy    <= 1'b0;
    end else begin
      // a new edge wins over the acknowledge clear of the same bit
      bus.pending <= (bus.pending & ~clr) | rise;
      if (bus.mask_we) bus.mask <= bus.mask_wdata;
      case (state)
        IDLE: begin
          if (|eligible) begin
            bus.int_vec <= winner;
            bus.intr    <= 1'b1;
            bus.busy    <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            bus.intr <= 1'b0;
            state    <= SERVICE;
          end
        end
        SERVICE: begin
          if (bus.rti) begin
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          bus.intr <= 1'b0;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus random traffic,
// all checked each cycle against a behavioural reference model.
module tb_int_ctrl;
  localparam int NSRC = 4;
  localparam int SS   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_ctrl_if #(.NSRC(NSRC)) bus ();
  int_ctrl #(.NSRC(NSRC), .SYNC_STAGES(SS)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: history of sampled request lines, newest first
  logic [NSRC-1:0] hist [SS+1];
  logic [NSRC-1:0] m_pend, m_mask;
  logic            m_int, m_busy;
  logic [1:0]      m_vec;
  int              m_phase;  // 0 waiting, 1 requesting, 2 in ISR

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [NSRC-1:0] seen, elig, nxt;
    int win;
    if (rst) begin
      for (int i = 0; i <= SS; i++) hist[i] = '0;
      m_pend = '0; m_mask = '0; m_int = 0; m_busy = 0; m_vec = '0; m_phase = 0;
      return;
    end
    // a source requests when its line was first seen high SS cycles ago
    seen = hist[SS-1] & ~hist[SS];
    elig = m_pend & ~m_mask;
    win  = -1;
    for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) win = i;
    nxt = m_pend;
    if (m_phase == 1 && bus.int_ack) nxt[m_vec] = 1'b0;
    nxt = nxt | seen;
    for (int i = SS; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = bus.irq_in;
    if (bus.mask_we) m_mask = bus.mask_wdata;
    case (m_phase)
      0: if (win >= 0) begin m_vec = 2'(win); m_int = 1; m_busy = 1; m_phase = 1; end
      1: if (bus.int_ack) begin m_int = 0; m_phase = 2; end
      default: if (bus.rti) begin m_busy = 0; m_phase = 0; end
    endcase
    m_pend = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("int",     {7'd0, bus.intr},    {7'd0, m_int});
    chk("int_vec", {6'd0, bus.int_vec}, {6'd0, m_vec});
    chk("pending", {4'd0, bus.pending}, {4'd0, m_pend});
    chk("mask",    {4'd0, bus.mask},    {4'd0, m_mask});
    chk("busy",    {7'd0, bus.busy},    {7'd0, m_busy});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    bus.irq_in = '0; bus.mask_we = 0; bus.mask_wdata = '0; bus.int_ack = 0; bus.rti = 0;
    @(negedge clk);
    ticks(3);
    rst = 1'b0;
    chk("rst_int",  {7'd0, bus.intr},    8'd0);
    chk("rst_pend", {4'd0, bus.pending}, 8'd0);
    chk("rst_mask", {4'd0, bus.mask},    8'd0);
    chk("rst_busy", {7'd0, bus.busy},    8'd0);

    // single request on source 2, level held
    bus.irq_in = 4'b0100;
    ticks(3);
    chk("single_pend", {4'd0, bus.pending}, 8'h04);
    chk("single_int_early", {7'd0, bus.intr}, 8'd0);
    tick();
    chk("single_int", {7'd0, bus.intr}, 8'd1);
    chk("single_vec", {6'd0, bus.int_vec}, 8'd2);
    bus.int_ack = 1; tick(); bus.int_ack = 0;
    chk("ack_int",  {7'd0, bus.intr},    8'd0);
    chk("ack_pend", {4'd0, bus.pending}, 8'd0);
    chk("ack_busy", {7'd0, bus.busy},    8'd1);
    bus.rti = 1; tick(); bus.rti = 0;
    chk("rti_busy", {7'd0, bus.busy}, 8'd0);
    ticks(4);
    chk("held_no_rereq", {7'd0, bus.intr}, 8'd0);

    // priority: sources 3 and 1 together
    bus.irq_in = 4'b1010;
    ticks(4);
    chk("prio_int", {7'd0, bus.intr},    8'd1);
    chk("prio_vec", {6'd0, bus.int_vec}, 8'd1);
    bus.int_ack = 1; tick(); bus.int_ack = 0;
    bus.rti = 1; tick(); bus.rti = 0;
    chk("prio_gap", {7'd0, bus.intr}, 8'd0);
    tick();
    chk("prio_int2", {7'd0, bus.intr},    8'd1);
    chk("prio_vec2", {6'd0, bus.int_vec}, 8'd3);
    bus.int_ack = 1; tick(); bus.int_ack = 0;
    bus.rti = 1; tick(); bus.rti = 0;
    bus.irq_in = '0;
    ticks(3);

    // masking
    bus.mask_we = 1; bus.mask_wdata = 4'b0001; tick(); bus.mask_we = 0;
    bus.irq_in = 4'b0001;
    ticks(5);
    chk("mask_pend", {4'd0, bus.pending}, 8'h01);
    chk("mask_int",  {7'd0, bus.intr},    8'd0);
    bus.mask_we = 1; bus.mask_wdata = 4'b0000; tick(); bus.mask_we = 0;
    chk("unmask_gap", {7'd0, bus.intr}, 8'd0);
    tick();
    chk("unmask_int", {7'd0, bus.intr},    8'd1);
    chk("unmask_vec", {6'd0, bus.int_vec}, 8'd0);
    bus.mask_we = 1; bus.mask_wdata = 4'b0001; tick(); bus.mask_we = 0;
    tick();
    chk("req_mask_hold", {7'd0, bus.intr}, 8'd1);
    bus.int_ack = 1; tick(); bus.int_ack = 0;
    bus.rti = 1; tick(); bus.rti = 0;
    bus.mask_we = 1; bus.mask_wdata = '0; tick(); bus.mask_we = 0;

    // collision: new edge on 2 lands with the ack of 2
    bus.irq_in = 4'b0101;
    ticks(4);
    chk("coll_vec", {6'd0, bus.int_vec}, 8'd2);
    bus.irq_in = 4'b0001; ticks(3);
    bus.irq_in = 4'b0101; ticks(2);
    bus.int_ack = 1; tick(); bus.int_ack = 0;
    chk("coll_pend2", {7'd0, bus.pending[2]}, 8'd1);
    chk("coll_int",   {7'd0, bus.intr},       8'd0);
    bus.int_ack = 1; tick(); bus.int_ack = 0;
    chk("ack_in_service", {7'd0, bus.pending[2]}, 8'd1);
    bus.rti = 1; tick(); bus.rti = 0;
    tick();
    chk("coll_rereq", {7'd0, bus.intr}, 8'd1);
    bus.rti = 1; tick(); bus.rti = 0;
    chk("rti_in_req", {7'd0, bus.intr}, 8'd1);
    bus.int_ack = 1; tick(); bus.int_ack = 0;
    bus.rti = 1; tick(); bus.rti = 0;
    bus.int_ack = 1; tick(); bus.int_ack = 0;
    chk("ack_in_idle", {7'd0, bus.busy}, 8'd0);

    // reset during service with source 3 still pending
    bus.irq_in = '0; ticks(3);
    bus.irq_in = 4'b1010; ticks(4);
    bus.int_ack = 1; tick(); bus.int_ack = 0;
    chk("svc_pend", {4'd0, bus.pending}, 8'h08);
    rst = 1; bus.irq_in = '0; ticks(2); rst = 0;
    chk("mid_rst_int",  {7'd0, bus.intr},    8'd0);
    chk("mid_rst_pend", {4'd0, bus.pending}, 8'd0);
    ticks(6);
    chk("mid_rst_quiet", {7'd0, bus.busy}, 8'd0);

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < NSRC; b++)
        if ($urandom_range(0, 7) == 0) bus.irq_in[b] = ~bus.irq_in[b];
      bus.mask_we    = ($urandom_range(0, 15) == 0);
      bus.mask_wdata = 4'($urandom);
      bus.int_ack    = (m_phase == 1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      bus.rti        = (m_phase == 2) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
      rst            = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
